// File: rtl/key_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_sched_pkg
//  Description : Shared types, defaults and helpers for key_event_scheduler.
//                The event record is sized for the largest supported key count
//                so one type serves every build of the scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
package key_sched_pkg;

    localparam int DEF_N_KEYS       = 4;
    localparam int DEF_TICK_DIV     = 50000;
    localparam int DEF_STABLE_TICKS = 10;
    localparam int DEF_FIFO_DEPTH   = 4;
    localparam int MAX_N_KEYS       = 8;

    // Width of a key index for a given number of keys (at least one bit).
    function automatic int key_width(input int n_keys);
        return (n_keys > 1) ? $clog2(n_keys) : 1;
    endfunction

    localparam int KEY_W = key_width(MAX_N_KEYS);

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic             press;
    } key_evt_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with registered full/empty flags and
//                simultaneous push/pop. DEPTH must be a power of two so the
//                read/write pointers wrap naturally.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_next;
    logic [AW-1:0]    rd_next;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is dropped here; the caller never issues one.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign wr_next = wr_ptr + AW'(1);
    assign rd_next = rd_ptr + AW'(1);

    // Storage array: written on accepted push, contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and registered occupancy flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_next;
            end
            if (do_pop) begin
                rd_ptr <= rd_next;
            end
            if (do_push && !do_pop) begin
                empty <= 1'b0;
                full  <= (wr_next == rd_ptr);
            end else if (do_pop && !do_push) begin
                full  <= 1'b0;
                empty <= (rd_next == wr_ptr);
            end
        end
    end

    assign pop_data = mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/key_event_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : key_event_scheduler
//  Description : Debounces active-low push-buttons against a shared tick,
//                produces clean active-high levels and serialises press /
//                release events through a round-robin arbiter into a small
//                valid/ready event FIFO. Lost events raise a sticky flag.
//  Revision    : 1.0  initial release
// ============================================================================
module key_event_scheduler
    import key_sched_pkg::*;
#(
    parameter int N_KEYS       = DEF_N_KEYS,
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_KEYS-1:0]         keys_n,
    output logic [N_KEYS-1:0]         key_level,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [$clog2(N_KEYS)-1:0] evt_key,
    output logic                      evt_press,
    output logic                      overflow,
    input  logic                      clr_overflow
);
    localparam int KW    = $clog2(N_KEYS);
    localparam int CNT_W = $clog2(STABLE_TICKS + 1);
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_TICKS - 1);
    localparam logic [KW:0]      N_WIDE    = (KW + 1)'(N_KEYS);
    localparam logic [KW-1:0]    KEY_LAST  = KW'(N_KEYS - 1);

    logic [N_KEYS-1:0] sync_meta;
    logic [N_KEYS-1:0] sync_out;
    logic [N_KEYS-1:0] pressed;
    logic [DIV_W-1:0]  div_cnt;
    logic              tick;
    logic [CNT_W-1:0]  stable_cnt [N_KEYS];
    logic [N_KEYS-1:0] toggle;
    logic [N_KEYS-1:0] pending;
    logic [N_KEYS-1:0] dir;
    logic [KW-1:0]     ptr;
    logic              grant_valid;
    logic [KW-1:0]     grant_idx;
    logic [N_KEYS-1:0] grant_mask;
    logic [KW:0]       cand;
    logic              overflow_set;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    key_evt_t          push_evt;
    key_evt_t          head_evt;
    logic              unused_head_bits;

    // Two-flop synchroniser per key; resets to the released (high) level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= '1;
            sync_out  <= '1;
        end else begin
            sync_meta <= keys_n;
            sync_out  <= sync_meta;
        end
    end

    assign pressed = ~sync_out;

    // Shared prescaler producing a one-cycle tick every TICK_DIV cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign tick = (div_cnt == TICK_LAST);

    generate
        for (genvar k = 0; k < N_KEYS; k++) begin : g_key
            // Accept the new level on the tick that completes the stable run.
            assign toggle[k] = tick && (pressed[k] != key_level[k])
                               && (stable_cnt[k] == CNT_LAST);

            // Count ticks of continuous disagreement; any agreement restarts.
            always_ff @(posedge clk) begin
                if (rst) begin
                    stable_cnt[k] <= '0;
                end else if (pressed[k] == key_level[k]) begin
                    stable_cnt[k] <= '0;
                end else if (tick) begin
                    stable_cnt[k] <= toggle[k] ? '0 : stable_cnt[k] + CNT_W'(1);
                end
            end
        end
    endgenerate

    // Round-robin search for the first pending key at or after ptr.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_mask  = '0;
        cand        = '0;
        if (!fifo_full) begin
            for (int i = 0; i < N_KEYS; i++) begin
                cand = {1'b0, ptr} + (KW + 1)'(i);
                if (cand >= N_WIDE) begin
                    cand = cand - N_WIDE;
                end
                if (!grant_valid && pending[cand[KW-1:0]]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand[KW-1:0];
                end
            end
        end
        if (grant_valid) begin
            grant_mask[grant_idx] = 1'b1;
        end
    end

    // Rotate the arbitration start point past the key just served.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_valid) begin
            ptr <= (grant_idx == KEY_LAST) ? '0 : grant_idx + KW'(1);
        end
    end

    // Debounced levels, event direction and the pending-event mask.
    // A fresh toggle re-arms pending even on the key being granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_level <= '0;
            dir       <= '0;
            pending   <= '0;
        end else begin
            for (int k = 0; k < N_KEYS; k++) begin
                if (toggle[k]) begin
                    key_level[k] <= ~key_level[k];
                    dir[k]       <= ~key_level[k];
                end
            end
            pending <= (pending & ~grant_mask) | toggle;
        end
    end

    // An event is lost only when a toggle lands on a pending key that is not
    // being pushed this same cycle; the granted key's old event is saved.
    assign overflow_set = |(toggle & pending & ~grant_mask);

    // Sticky lost-event flag; a new loss beats a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (overflow_set) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    assign push_evt.key   = KEY_W'(grant_idx);
    assign push_evt.press = dir[grant_idx];
    assign fifo_pop       = evt_valid && evt_ready;

    sync_fifo #(
        .WIDTH ($bits(key_evt_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (grant_valid),
        .push_data (push_evt),
        .pop       (fifo_pop),
        .pop_data  (head_evt),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Head fields read as zero whenever no event is presented.
    assign evt_valid        = ~fifo_empty;
    assign evt_key          = evt_valid ? head_evt.key[KW-1:0] : '0;
    assign evt_press        = evt_valid & head_evt.press;
    assign unused_head_bits = ^head_evt.key;

endmodule
`default_nettype wire

// File: doc/key_event_scheduler.md
# key_event_scheduler

Converts up to N_KEYS raw, active-low DE-10 Lite push-buttons into clean levels and a queued stream of press/release events for the multiplication FSM. All keys share one millisecond tick prescaler, replacing one free-running 20-bit counter per button. Simultaneous key changes are serialised by a round-robin arbiter into a small event FIFO with a valid/ready handshake. It sits between the board pins and the top-level control FSM.

## Interface
- N_KEYS, 4, number of buttons (2..8)
- TICK_DIV, 50000, clk cycles per debounce tick (1 ms at 50 MHz)
- STABLE_TICKS, 10, consecutive ticks of disagreement required to accept a new level
- FIFO_DEPTH, 4, event FIFO entries (power of two, >= 2)
- clk  in  1  50 MHz system clock; one clock domain; all logic on posedge clk
- rst  in  1  synchronous, active-high reset
- keys_n  in  N_KEYS  raw buttons, active low, asynchronous to clk
- key_level  out  N_KEYS  debounced levels, active high (1 = pressed)
- evt_valid  out  1  FIFO head is valid
- evt_ready  in  1  consumer accepts the head this cycle
- evt_key  out  $clog2(N_KEYS)  key index of the head event
- evt_press  out  1  1 = press, 0 = release
- overflow  out  1  sticky lost-event flag
- clr_overflow  in  1  clears overflow

## Operation
- Reset values: key_level = 0, evt_valid = 0, evt_key = 0, evt_press = 0, overflow = 0. Synchronisers reset to 1 (released). Prescaler, stable counters, pending mask and FIFO are cleared, and the RR pointer is set to 0.
- Synchroniser: 2 flops per key; sync_k = ~keys_n stage 2.
- Prescaler: counts 0..TICK_DIV-1 and wraps; tick = 1 for one cycle when the count equals TICK_DIV-1.
- Per-key stable counter, width $clog2(STABLE_TICKS+1):
  - If sync_k == key_level[k], the counter clears every cycle, whether or not tick is high.
  - On tick with disagreement: if counter == STABLE_TICKS-1, key_level[k] toggles, the counter clears, pending[k] is set and dir[k] is set to the new level. Otherwise the counter increments.
- Toggle while pending[k] is already set: dir[k] is overwritten, pending[k] stays set, and overflow is set.
- Arbiter:
  - Each cycle the FIFO is not full and pending is non-zero, it grants the lowest pending index >= ptr, wrapping.
  - The grant pushes {k, dir[k]} into the FIFO and clears pending[k]. A toggle on the granted key in the same cycle re-sets pending[k]; the set wins.
  - ptr <= grant+1 mod N_KEYS. ptr is unchanged when there is no grant.
- FIFO:
  - Pop when evt_valid && evt_ready.
  - Push and pop in the same cycle are both honoured.
  - When full, push is blocked and events wait in the pending mask; backpressure never loses events by itself.
  - evt_valid = FIFO non-empty. Head fields hold stable while evt_valid && !evt_ready.
- overflow: the set condition has priority over clr_overflow in the same cycle.
- rst mid-operation: pending events and FIFO contents are discarded, with no release events emitted for held keys. key_level returns to 0. A still-held key re-reports a press after STABLE_TICKS ticks.

## Timing
- Sync latency: 2 cycles.
- Debounce acceptance: STABLE_TICKS ticks after the first tick that sees the disagreement. This is (STABLE_TICKS-1)*TICK_DIV+1 to STABLE_TICKS*TICK_DIV cycles after sync_k changes.
- key_level toggle and pending set occur on the same edge (cycle T).
- FIFO push is at T+1 if granted. evt_valid is high at T+2 when the FIFO was empty.
- Three keys accepted on the same tick are pushed on three consecutive cycles, in RR order.
- Any glitch shorter than one full tick interval of disagreement never changes key_level.

## Structure
- Package key_sched_pkg holds:
  - typedef key_evt_t {logic [KEY_W-1:0] key; logic press;}
  - function to compute KEY_W from N_KEYS
  - default parameter constants
- Sub-module sync_fifo, parameterised on width and depth:
  - registered full/empty
  - simultaneous push/pop
  - synchronous active-high reset
- The top level holds the synchronisers, prescaler, per-key counters, pending/dir registers, RR arbiter and overflow logic.

## Test plan
Simulation parameters: N_KEYS=4, TICK_DIV=4, STABLE_TICKS=3, FIFO_DEPTH=4.
- Reset, all keys released -> key_level=0000, evt_valid=0, overflow=0 for 100 cycles.
- Key 2 pressed steadily -> key_level[2] rises 9-12 cycles after the sync output changes. One event follows {key=2, press=1}, with evt_valid 2 cycles after the level change. Release produces {2, 0}.
- Key 1 bounce with a 6-cycle low pulse then high -> key_level unchanged, no event.
- Keys 0, 1, 3 accepted on the same tick, ptr=1 -> events pop in order 1, 3, 0 on consecutive cycles with evt_ready=1.
- evt_ready=0, then 6 distinct key changes:
  - 4 events fill the FIFO and 2 remain pending.
  - overflow stays 0.
  - Raising evt_ready drains all 6 in order with no loss.
- Key 0 toggles twice while its event is stalled -> overflow=1. clr_overflow=1 -> 0 next cycle. rst asserted mid-queue -> evt_valid=0 the next cycle.
